// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage buffer.
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Control value presented while the head is a bubble; wide enough for any CTRL_W.
  localparam logic [63:0] BUBBLE_CTRL = '0;

  // Number of held entries for a given occupancy state.
  function automatic logic [1:0] occ_count(occ_e s);
    case (s)
      OCC_ONE: return 2'd1;
      OCC_TWO: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage entry: valid flag plus a W-bit payload register.
// Clear drops only the valid flag; the payload keeps its last value.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Clear wins over load so a flush can never leave a stale valid entry.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end
  end

  // Entry registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage register with optional two-entry skid buffer,
// flush-to-bubble and a saturating stall counter.
//
// state     | meaning
// ----------+-----------------------------------------------
// OCC_EMPTY | nothing held, out_valid=0
// OCC_ONE   | head entry valid, skid empty
// OCC_TWO   | head and skid both valid, input blocked (SKID=1 only)
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W      = 16,
  parameter int DATA_W      = 64,
  parameter int SKID        = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   flush,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  input  logic                   stall_clr
);

  localparam int ENT_W = CTRL_W + DATA_W;
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  occ_e state_q, state_d;

  logic             push, pop;
  logic             head_load, head_clr, head_src_skid;
  logic             skid_load, skid_clr;
  logic             head_valid, skid_valid;
  logic [ENT_W-1:0] head_q, skid_q, head_d, in_ent;
  logic [CTRL_W-1:0] head_ctrl;

  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign in_ent = {in_ctrl, in_data};
  assign push   = in_valid & in_ready & ~flush;
  assign pop    = head_valid & out_ready;

  // With the skid entry, in_ready is a pure decode of the state flop so the
  // upstream stage never sees a path from out_ready.
  generate
    if (SKID == 1) begin : g_rdy_reg
      assign in_ready = (state_q != OCC_TWO);
    end else begin : g_rdy_comb
      assign in_ready = ~head_valid | out_ready;
    end
  endgenerate

  // Next-state and slot control; flush overrides every other transition.
  always_comb begin
    state_d       = state_q;
    head_load     = 1'b0;
    head_clr      = 1'b0;
    head_src_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clr      = 1'b0;
    if (flush) begin
      state_d  = OCC_EMPTY;
      head_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (push) begin
            head_load = 1'b1;
            state_d   = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head_load = 1'b1;
          end else if (push && SKID == 1) begin
            skid_load = 1'b1;
            state_d   = OCC_TWO;
          end else if (pop) begin
            head_clr = 1'b1;
            state_d  = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (pop) begin
            head_load     = 1'b1;
            head_src_skid = 1'b1;
            skid_clr      = 1'b1;
            state_d       = OCC_ONE;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= OCC_EMPTY;
    else     state_q <= state_d;
  end

  // Head refills from the skid entry when draining from TWO, else from the input.
  always_comb begin
    head_d = in_ent;
    if (head_src_skid) head_d = skid_q;
  end

  pipe_slot #(.W(ENT_W)) u_head (
    .clk   (clk),
    .rst   (rst),
    .load  (head_load),
    .clr   (head_clr),
    .d     (head_d),
    .valid (head_valid),
    .q     (head_q)
  );

  generate
    if (SKID == 1) begin : g_skid
      pipe_slot #(.W(ENT_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clr   (skid_clr),
        .d     (in_ent),
        .valid (skid_valid),
        .q     (skid_q)
      );
    end else begin : g_no_skid
      logic unused_skid_ctl;
      assign unused_skid_ctl = skid_load | skid_clr | skid_valid;
      assign skid_valid      = 1'b0;
      assign skid_q          = '0;
    end
  endgenerate

  // Saturating stall counter; clear takes precedence over counting.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if (head_valid && !out_ready && stall_cnt_q != STALL_MAX) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign head_ctrl = head_q[DATA_W +: CTRL_W];
  assign out_valid = head_valid;
  assign out_ctrl  = head_valid ? head_ctrl : CTRL_W'(BUBBLE_CTRL);
  assign out_data  = head_q[DATA_W-1:0];
  assign occupancy = occ_count(state_q);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: one SKID=1 and one SKID=0 instance share all
// inputs; each is checked every cycle against a queue model.
module tb_pipe_stage_buf;

  localparam int CW = 16;
  localparam int DW = 64;
  localparam int SW = 4;
  localparam int SMAX = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, out_ready, flush, stall_clr;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          in_ready_o  [2];
  logic          out_valid_o [2];
  logic [CW-1:0] out_ctrl_o  [2];
  logic [DW-1:0] out_data_o  [2];
  logic [1:0]    occ_o       [2];
  logic [SW-1:0] stall_o     [2];

  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .STALL_CNT_W(SW)) u_skid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[0]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_o[0]),
    .out_ready(out_ready), .out_ctrl(out_ctrl_o[0]), .out_data(out_data_o[0]),
    .flush(flush), .occupancy(occ_o[0]), .stall_cnt(stall_o[0]), .stall_clr(stall_clr)
  );

  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .STALL_CNT_W(SW)) u_noskid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_o[1]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_o[1]),
    .out_ready(out_ready), .out_ctrl(out_ctrl_o[1]), .out_data(out_data_o[1]),
    .flush(flush), .occupancy(occ_o[1]), .stall_cnt(stall_o[1]), .stall_clr(stall_clr)
  );

  // Model: index 0 = capacity 2 (skid), index 1 = capacity 1.
  int            m_n     [2];
  logic [CW-1:0] m_c     [2][2];
  logic [DW-1:0] m_d     [2][2];
  logic [DW-1:0] m_last  [2];
  int            m_stall [2];

  int n_chk  = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic m_rdy(input int m);
    if (m == 0) return (m_n[0] < 2);
    return (m_n[1] == 0) || out_ready;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_n[m] = 0;
      m_last[m] = '0;
      m_stall[m] = 0;
    end
  endtask

  // Called at a rising edge with the pre-edge input values still applied.
  task automatic model_update();
    logic push [2];
    logic pop  [2];
    for (int m = 0; m < 2; m++) begin
      push[m] = in_valid && m_rdy(m) && !flush;
      pop[m]  = (m_n[m] > 0) && out_ready;
    end
    for (int m = 0; m < 2; m++) begin
      if (stall_clr) m_stall[m] = 0;
      else if (m_n[m] > 0 && !out_ready && m_stall[m] < SMAX) m_stall[m]++;
      if (flush) begin
        m_n[m] = 0;
      end else begin
        if (pop[m]) begin
          m_c[m][0] = m_c[m][1];
          m_d[m][0] = m_d[m][1];
          m_n[m]--;
        end
        if (push[m]) begin
          m_c[m][m_n[m]] = in_ctrl;
          m_d[m][m_n[m]] = in_data;
          m_n[m]++;
        end
      end
      if (m_n[m] > 0) m_last[m] = m_d[m][0];
    end
  endtask

  task automatic compare_all();
    if (rst) return;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("out_valid[%0d]", m), 64'(out_valid_o[m]), 64'(m_n[m] > 0));
      chk($sformatf("out_ctrl[%0d]", m), 64'(out_ctrl_o[m]), (m_n[m] > 0) ? 64'(m_c[m][0]) : 64'd0);
      chk($sformatf("out_data[%0d]", m), 64'(out_data_o[m]), 64'(m_last[m]));
      chk($sformatf("occupancy[%0d]", m), 64'(occ_o[m]), 64'(m_n[m]));
      chk($sformatf("in_ready[%0d]", m), 64'(in_ready_o[m]), 64'(m_rdy(m)));
      chk($sformatf("stall_cnt[%0d]", m), 64'(stall_o[m]), 64'(m_stall[m]));
    end
  endtask

  // Advance one clock, update the model at the edge, check outputs mid-cycle.
  task automatic step();
    @(posedge clk);
    model_update();
    #4;
    compare_all();
  endtask

  task automatic set_in(input logic v, input logic [CW-1:0] c);
    in_valid = v;
    in_ctrl  = c;
    in_data  = {$urandom, $urandom};
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; stall_clr = 1'b0;
    in_ctrl = '0; in_data = '0;
    model_reset();
    #12 rst = 1'b0;
    #1;
    chk("reset_in_ready", 64'(in_ready_o[0]), 64'd1);
    chk("reset_out_valid", 64'(out_valid_o[0]), 64'd0);
    chk("reset_out_data", 64'(out_data_o[0]), 64'd0);
    chk("reset_occ", 64'(occ_o[0]), 64'd0);
    step();

    // Back-to-back stream with no backpressure.
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b1, CW'(i));
      step();
      chk("stream_ctrl", 64'(out_ctrl_o[0]), 64'(i));
      chk("stream_in_ready", 64'(in_ready_o[0]), 64'd1);
      chk("stream_occ", 64'(occ_o[0]), 64'd1);
    end
    set_in(1'b0, '0);
    step();

    // Backpressure fills the skid, then drains in order.
    out_ready = 1'b0;
    set_in(1'b1, 16'h00AA); step();
    set_in(1'b1, 16'h00BB); step();
    chk("bp_occ", 64'(occ_o[0]), 64'd2);
    chk("bp_in_ready", 64'(in_ready_o[0]), 64'd0);
    set_in(1'b1, 16'h00CC); step(); step();
    chk("bp_hold_head", 64'(out_ctrl_o[0]), 64'h00AA);
    chk("bp_hold_occ", 64'(occ_o[0]), 64'd2);
    out_ready = 1'b1;
    step();
    chk("bp_second", 64'(out_ctrl_o[0]), 64'h00BB);
    step();
    chk("bp_third", 64'(out_ctrl_o[0]), 64'h00CC);
    set_in(1'b0, '0);
    step();
    chk("bp_drained", 64'(out_valid_o[0]), 64'd0);

    // Flush from TWO with a beat presented.
    out_ready = 1'b0;
    set_in(1'b1, 16'h0011); step();
    set_in(1'b1, 16'h0022); step();
    chk("flush_pre_occ", 64'(occ_o[0]), 64'd2);
    set_in(1'b1, 16'h00DD);
    flush = 1'b1;
    step();
    flush = 1'b0;
    set_in(1'b0, '0);
    chk("flush_valid", 64'(out_valid_o[0]), 64'd0);
    chk("flush_ctrl", 64'(out_ctrl_o[0]), 64'd0);
    chk("flush_occ", 64'(occ_o[0]), 64'd0);
    out_ready = 1'b1;
    repeat (3) step();
    chk("flush_no_d", 64'(out_valid_o[0]), 64'd0);

    // Asynchronous reset between edges while in TWO.
    out_ready = 1'b0;
    set_in(1'b1, 16'h0033); step();
    set_in(1'b1, 16'h0044); step();
    set_in(1'b0, '0);
    chk("rst_pre_occ", 64'(occ_o[0]), 64'd2);
    #3 rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_valid", 64'(out_valid_o[0]), 64'd0);
    chk("async_rst_ctrl", 64'(out_ctrl_o[0]), 64'd0);
    chk("async_rst_occ", 64'(occ_o[0]), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready_o[0]), 64'd1);

    // Single-entry variant: combinational ready and head replacement.
    out_ready = 1'b0;
    set_in(1'b1, 16'h0055); step();
    set_in(1'b1, 16'h0066);
    #1;
    chk("noskid_blocked", 64'(in_ready_o[1]), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("noskid_comb_ready", 64'(in_ready_o[1]), 64'd1);
    step();
    chk("noskid_replaced", 64'(out_ctrl_o[1]), 64'h0066);
    set_in(1'b0, '0);
    step();

    // Stall counter saturation and clear.
    out_ready = 1'b0;
    stall_clr = 1'b1;
    set_in(1'b1, 16'h0077);
    step();
    stall_clr = 1'b0;
    set_in(1'b0, '0);
    repeat (20) step();
    chk("stall_sat", 64'(stall_o[0]), 64'd15);
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    chk("stall_clr", 64'(stall_o[0]), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 3) != 0, CW'($urandom));
      out_ready = (i % 200 < 40) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      stall_clr = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, errors);
    $finish;
  end

endmodule
